counter_ctrl: RTL and testbench



---
 rtl/counter_ctrl.sv | 102 ++++++++++
 tb/tb_counter_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - start/pause/stop sequencer for a 0..limit up-counter
// Optional build macro COUNTER_CTRL_AUTORELOAD_EN: DONE restarts the run instead of returning to IDLE.
module counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    limit_d = limit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          limit_d = limit;
          q_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The terminal compare precedes the increment, so q never wraps.
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (q_q == limit_q) begin
          state_d = DONE;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (!pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
`ifdef COUNTER_CTRL_AUTORELOAD_EN
        if (stop) begin
          state_d = IDLE;
        end else begin
          limit_d = limit;
          q_d     = '0;
          state_d = RUN;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      limit_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      limit_q <= limit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q     = q_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - vector table plus scoreboard bench for counter_ctrl
// Build with COUNTER_CTRL_AUTORELOAD_EN to exercise the reload sequence instead of the default table.
module tb_counter_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst, start, stop, pause;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] q;
  logic             busy, done;
  logic [1:0]       state;

  typedef struct packed {
    logic             rst;
    logic             start;
    logic             stop;
    logic             pause;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       st;
  } vec_t;

  vec_t table_v[$];
  vec_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  counter_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .limit (limit),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .state (state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic sp, input logic p,
                              input int lim, input int eq, input logic eb, input logic ed, input int es);
    vec_t v;
    v.rst = r; v.start = s; v.stop = sp; v.pause = p; v.limit = WIDTH'(lim);
    v.q = WIDTH'(eq); v.busy = eb; v.done = ed; v.st = 2'(es);
    return v;
  endfunction

  task automatic step(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    rst = v.rst; start = v.start; stop = v.stop; pause = v.pause; limit = v.limit;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_total++;
    if ({q, busy, done, state} === {e.q, e.busy, e.done, e.st}) n_pass++;
    else $display("FAIL %s: got q=%0d busy=%0b done=%0b state=%0d, want q=%0d busy=%0b done=%0b state=%0d",
                  nm, q, busy, done, state, e.q, e.busy, e.done, e.st);
  endtask

  // Idle-input helper: run one edge with only the given controls asserted.
  task automatic run(input logic s, input logic sp, input logic p, input int lim,
                     input int eq, input logic eb, input logic ed, input int es, input string nm);
    step(mk(1'b1, s, sp, p, lim, eq, eb, ed, es), nm);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; limit = '0;

    // reset while start is held
    table_v.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0));
    table_v.push_back(mk(0, 1, 0, 0, 5, 0, 0, 0, 0));
`ifndef COUNTER_CTRL_AUTORELOAD_EN
    // basic run, limit 5; limit changes after acceptance are ignored
    table_v.push_back(mk(1, 1, 0, 0, 5, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 1, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 2, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 3, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 4, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 5, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 3, 5, 1, 1, 3));
    table_v.push_back(mk(1, 0, 0, 0, 3, 5, 0, 0, 0));
    table_v.push_back(mk(1, 0, 0, 0, 3, 5, 0, 0, 0));
    // start during RUN ignored
    table_v.push_back(mk(1, 1, 0, 0, 2, 0, 1, 0, 1));
    table_v.push_back(mk(1, 1, 0, 0, 7, 1, 1, 0, 1));
    table_v.push_back(mk(1, 1, 0, 0, 7, 2, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 7, 2, 1, 1, 3));
    table_v.push_back(mk(1, 0, 0, 0, 7, 2, 0, 0, 0));
    // start+stop in IDLE accepted; limit 0 completes next edge
    table_v.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 3));
    table_v.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // abort at q=2
    table_v.push_back(mk(1, 1, 0, 0, 9, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 9, 1, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 9, 2, 1, 0, 1));
    table_v.push_back(mk(1, 0, 1, 0, 9, 2, 0, 0, 0));
    table_v.push_back(mk(1, 0, 0, 0, 9, 2, 0, 0, 0));
    // stop while paused
    table_v.push_back(mk(1, 1, 0, 0, 3, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 1, 3, 0, 1, 0, 2));
    table_v.push_back(mk(1, 0, 1, 1, 3, 0, 0, 0, 0));
    // pause beats terminal; DONE one edge after resume
    table_v.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 2));
    table_v.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 1, 1, 1, 1, 3));
    table_v.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    // start held through DONE: one IDLE cycle, then accepted
    table_v.push_back(mk(1, 1, 0, 0, 1, 0, 1, 0, 1));
    table_v.push_back(mk(1, 1, 0, 0, 1, 1, 1, 0, 1));
    table_v.push_back(mk(1, 1, 0, 0, 1, 1, 1, 1, 3));
    table_v.push_back(mk(1, 1, 0, 0, 2, 1, 0, 0, 0));
    table_v.push_back(mk(1, 1, 0, 0, 2, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 1, 0, 2, 0, 0, 0, 0));
    // reset mid-run
    table_v.push_back(mk(1, 1, 0, 0, 6, 0, 1, 0, 1));
    table_v.push_back(mk(1, 0, 0, 0, 6, 1, 1, 0, 1));
    table_v.push_back(mk(0, 0, 0, 0, 6, 0, 0, 0, 0));
`endif
    for (int i = 0; i < table_v.size(); i++) step(table_v[i], $sformatf("vec%0d", i));

`ifndef COUNTER_CTRL_AUTORELOAD_EN
    // limit 9 with pause held for three edges at q=4
    run(1, 0, 0, 9, 0, 1, 0, 1, "pz_start");
    for (int k = 1; k <= 4; k++) run(0, 0, 0, 9, k, 1, 0, 1, $sformatf("pz_up%0d", k));
    run(0, 0, 1, 9, 4, 1, 0, 2, "pz_enter");
    run(0, 0, 1, 9, 4, 1, 0, 2, "pz_hold1");
    run(0, 0, 1, 9, 4, 1, 0, 2, "pz_hold2");
    run(0, 0, 0, 9, 4, 1, 0, 1, "pz_resume");
    for (int k = 5; k <= 9; k++) run(0, 0, 0, 9, k, 1, 0, 1, $sformatf("pz_up%0d", k));
    run(0, 0, 0, 9, 9, 1, 1, 3, "pz_done");
    run(0, 0, 0, 9, 9, 0, 0, 0, "pz_idle");

    // full-range run: q stops at 15 without wrapping
    run(1, 0, 0, 15, 0, 1, 0, 1, "max_start");
    for (int k = 1; k <= 15; k++) run(0, 0, 0, 0, k, 1, 0, 1, $sformatf("max_up%0d", k));
    run(0, 0, 0, 0, 15, 1, 1, 3, "max_done");
    run(0, 0, 0, 0, 15, 0, 0, 0, "max_idle");
`else
    // reload: q 0,1,2,2(DONE) repeating until stop
    run(1, 0, 0, 2, 0, 1, 0, 1, "ar_start");
    for (int r = 0; r < 3; r++) begin
      run(0, 0, 0, 2, 1, 1, 0, 1, $sformatf("ar%0d_q1", r));
      run(0, 0, 0, 2, 2, 1, 0, 1, $sformatf("ar%0d_q2", r));
      run(0, 0, 0, 2, 2, 1, 1, 3, $sformatf("ar%0d_done", r));
      run(0, 0, 0, 2, 0, 1, 0, 1, $sformatf("ar%0d_reload", r));
    end
    run(0, 1, 0, 2, 0, 0, 0, 0, "ar_stop");
    run(0, 0, 0, 2, 0, 0, 0, 0, "ar_idle");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
